// File: rtl/ram_arbiter.sv
// Two-port data RAM arbiter: CPU port A (byte/half/word) and loader port B (word).
// Round-robin grant in IDLE, registered request, one RAM access, one-cycle response.
module ram_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_signed,
  input  logic [ADDR_W+1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ready,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ready,
  output logic [31:0]       b_rdata,
  output logic              ram_rw,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state;
  logic              last_b;
  logic              port_b;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sgn_r;
  logic              err_r;
  logic [3:0]        sel_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;

  logic              grant_a;
  logic              grant_b;
  logic [3:0]        a_sel;
  logic [31:0]       a_din;
  logic              a_mis;
  logic [31:0]       ld;
  logic              resp;

  // Round-robin: on contention the port not served last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      grant_a = a_req && (!b_req || last_b);
      grant_b = b_req && !grant_a;
    end
  end

  // Port A lane select, lane-replicated data and alignment check.
  always_comb begin
    a_sel = 4'b0000;
    a_din = a_wdata;
    a_mis = 1'b0;
    unique case (1'b1)
      a_size == 2'b00: begin
        a_sel = 4'b0001 << a_addr[1:0];
        a_din = {4{a_wdata[7:0]}};
      end
      a_size == 2'b01: begin
        a_sel = a_addr[1] ? 4'b1100 : 4'b0011;
        a_din = {2{a_wdata[15:0]}};
        a_mis = a_addr[0];
      end
      a_size == 2'b10: begin
        a_sel = 4'b1111;
        a_mis = a_addr[1:0] != 2'b00;
      end
      default: a_mis = 1'b1;
    endcase
  end

  // FSM and request capture; RAM signals come only from these registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      port_b  <= 1'b0;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sgn_r   <= 1'b0;
      err_r   <= 1'b0;
      sel_r   <= 4'b0000;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_a) begin
            port_b  <= 1'b0;
            last_b  <= 1'b0;
            we_r    <= a_we;
            size_r  <= a_size;
            sgn_r   <= a_signed;
            err_r   <= a_mis;
            sel_r   <= a_sel;
            addr_r  <= a_addr[ADDR_W+1:2];
            wdata_r <= a_din;
            state   <= a_mis ? RESP : ACCESS;
          end else if (grant_b) begin
            port_b  <= 1'b1;
            last_b  <= 1'b1;
            we_r    <= b_we;
            size_r  <= 2'b10;
            sgn_r   <= 1'b0;
            err_r   <= 1'b0;
            sel_r   <= 4'b1111;
            addr_r  <= b_addr;
            wdata_r <= b_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sign-extend sub-word loads; stores and errors return zero.
  always_comb begin
    ld = ram_data_out;
    unique case (1'b1)
      we_r || err_r:
        ld = '0;
      !we_r && !err_r && sgn_r && size_r == 2'b00:
        ld = {{24{ram_data_out[7]}}, ram_data_out[7:0]};
      !we_r && !err_r && sgn_r && size_r == 2'b01:
        ld = {{16{ram_data_out[15]}}, ram_data_out[15:0]};
      default:
        ld = ram_data_out;
    endcase
  end

  assign resp        = state == RESP;
  assign ram_rw      = (state == ACCESS) && we_r;
  assign ram_sel     = (state == ACCESS) ? sel_r : 4'b0000;
  assign ram_addr    = addr_r;
  assign ram_data_in = wdata_r;
  assign a_ready     = resp && !port_b;
  assign b_ready     = resp && port_b;
  assign a_err       = a_ready && err_r;
  assign a_rdata     = a_ready ? ld : 32'h0;
  assign b_rdata     = b_ready ? ld : 32'h0;

endmodule
